// File: rtl/stream_accel_wrapper.sv
// stream_accel_wrapper: buffers one DMA frame, streams it into a frame core and drains the result frame.
// Optional ACCEL_FRAME_CNT_EN adds a 16-bit completed-frame counter output frame_cnt.
module stream_accel_wrapper #(
   parameter int DATA_W    = 32,
   parameter int FRAME_LEN = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_rd,
   output logic              core_next,
   output logic [DATA_W-1:0] core_in,
   input  logic              core_next_out,
   input  logic [DATA_W-1:0] core_out,
   output logic              dev_ready,
   output logic              dev_busy,
   output logic              frame_done,
   output logic              ovf_err,
   output logic              unf_err,
`ifdef ACCEL_FRAME_CNT_EN
   output logic [15:0]       frame_cnt,
`endif
   input  logic              err_clr
);
   localparam int CW = $clog2(FRAME_LEN + 1);
   localparam int PW = $clog2(FRAME_LEN);
   localparam logic [CW-1:0] FULL = CW'(FRAME_LEN);
   localparam logic [PW-1:0] PMAX = PW'(FRAME_LEN - 1);
   typedef enum logic [2:0] {IDLE, FILL_IN, STREAM, WAIT_OUT, FLUSH} state_t;
   state_t state_q, state_d;
   logic [DATA_W-1:0] in_mem_q [FRAME_LEN];
   logic [DATA_W-1:0] out_mem_q [FRAME_LEN];
   logic [PW-1:0] in_wp_q, in_wp_d, in_rp_q, in_rp_d, out_wp_q, out_wp_d, out_rp_q, out_rp_d;
   logic [CW-1:0] in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d, wr_cnt_q, wr_cnt_d;
   logic cap_q, cap_d, core_next_q, core_next_d, dev_ready_q, dev_ready_d, dev_busy_q, dev_busy_d;
   logic frame_done_q, frame_done_d, ovf_q, ovf_d, unf_q, unf_d;
   logic acc, rd, pop, wr, flush_done;

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return p == PMAX ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      s_ready = (state_q == IDLE || state_q == FILL_IN || state_q == FLUSH) && in_cnt_q != FULL;
      m_valid = out_cnt_q != '0;
      acc = s_valid & s_ready;
      rd = state_q == STREAM;
      pop = m_rd & m_valid;
      // wr_cnt_q stays at FULL until the frame drains, so a stray pulse cannot re-arm capture
      wr = cap_q | (core_next_out & (wr_cnt_q == '0) & (state_q == STREAM || state_q == WAIT_OUT));
      in_cnt_d = in_cnt_q + CW'(acc) - CW'(rd);
      out_cnt_d = out_cnt_q + CW'(wr) - CW'(pop);
      flush_done = state_q == FLUSH && out_cnt_d == '0;
      wr_cnt_d = flush_done ? '0 : wr_cnt_q + CW'(wr);
      cap_d = wr && wr_cnt_d != FULL;
      in_wp_d = acc ? inc(in_wp_q) : in_wp_q;
      in_rp_d = rd ? inc(in_rp_q) : in_rp_q;
      out_wp_d = wr ? inc(out_wp_q) : out_wp_q;
      out_rp_d = pop ? inc(out_rp_q) : out_rp_q;
      state_d = (state_q == IDLE || state_q == FILL_IN) ?
                   (in_cnt_d == FULL ? STREAM : in_cnt_d != '0 ? FILL_IN : state_q) :
                state_q == STREAM ?
                   (in_cnt_q == CW'(1) ? (wr_cnt_d == FULL ? FLUSH : WAIT_OUT) : STREAM) :
                state_q == WAIT_OUT ? (wr_cnt_d == FULL ? FLUSH : WAIT_OUT) :
                flush_done ? (in_cnt_d == FULL ? STREAM : in_cnt_d != '0 ? FILL_IN : IDLE) : FLUSH;
      core_next_d = state_d == STREAM && state_q != STREAM;
      dev_ready_d = state_d == IDLE;
      dev_busy_d = state_d == FILL_IN || state_d == STREAM || state_d == WAIT_OUT;
      frame_done_d = flush_done;
      ovf_d = (s_valid & ~s_ready) | (ovf_q & ~err_clr);
      unf_d = (m_rd & ~m_valid) | (unf_q & ~err_clr);
      core_in = rd ? in_mem_q[in_rp_q] : '0;
      m_data = m_valid ? out_mem_q[out_rp_q] : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         in_wp_q <= '0;
         in_rp_q <= '0;
         out_wp_q <= '0;
         out_rp_q <= '0;
         in_cnt_q <= '0;
         out_cnt_q <= '0;
         wr_cnt_q <= '0;
         cap_q <= 1'b0;
         core_next_q <= 1'b0;
         dev_ready_q <= 1'b1;
         dev_busy_q <= 1'b0;
         frame_done_q <= 1'b0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         state_q <= state_d;
         in_wp_q <= in_wp_d;
         in_rp_q <= in_rp_d;
         out_wp_q <= out_wp_d;
         out_rp_q <= out_rp_d;
         in_cnt_q <= in_cnt_d;
         out_cnt_q <= out_cnt_d;
         wr_cnt_q <= wr_cnt_d;
         cap_q <= cap_d;
         core_next_q <= core_next_d;
         dev_ready_q <= dev_ready_d;
         dev_busy_q <= dev_busy_d;
         frame_done_q <= frame_done_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (acc) in_mem_q[in_wp_q] <= s_data;
      if (wr) out_mem_q[out_wp_q] <= core_out;
   end

   assign core_next = core_next_q;
   assign dev_ready = dev_ready_q;
   assign dev_busy = dev_busy_q;
   assign frame_done = frame_done_q;
   assign ovf_err = ovf_q;
   assign unf_err = unf_q;

`ifdef ACCEL_FRAME_CNT_EN
   logic [15:0] frame_cnt_q, frame_cnt_d;
   always_comb frame_cnt_d = frame_cnt_q + 16'(flush_done);
   always_ff @(posedge clk) frame_cnt_q <= rst ? '0 : frame_cnt_d;
   assign frame_cnt = frame_cnt_q;
`endif
endmodule

// File: tb/tb_stream_accel_wrapper.sv
// tb_stream_accel_wrapper: scoreboard bench with an inline core model (result = ~input, configurable latency).
module tb_stream_accel_wrapper;
   localparam int F = 4;
   logic clk = 1'b0, rst = 1'b1;
   logic [7:0] s_data = '0, core_out = '0;
   logic s_valid = 1'b0, m_rd = 1'b0, core_next_out = 1'b0, err_clr = 1'b0;
   logic s_ready, m_valid, core_next, dev_ready, dev_busy, frame_done, ovf_err, unf_err;
   logic [7:0] m_data, core_in;
`ifdef ACCEL_FRAME_CNT_EN
   logic [15:0] frame_cnt;
`endif
   int n_tests = 0, n_fail = 0, cyc = 0, st = -1, lat = 3, fd_cnt = 0;
   bit spur = 1'b0, dr_seen = 1'b0;
   logic [7:0] exp_core [$];
   logic [7:0] exp_out [$];
   logic [7:0] rq [int];
   bit pq [int];

   always #5 clk = ~clk;

   stream_accel_wrapper #(.DATA_W(8), .FRAME_LEN(F)) dut (
      .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .m_data(m_data), .m_valid(m_valid), .m_rd(m_rd), .core_next(core_next), .core_in(core_in),
      .core_next_out(core_next_out), .core_out(core_out), .dev_ready(dev_ready), .dev_busy(dev_busy),
      .frame_done(frame_done), .ovf_err(ovf_err), .unf_err(unf_err),
`ifdef ACCEL_FRAME_CNT_EN
      .frame_cnt(frame_cnt),
`endif
      .err_clr(err_clr)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // one clock cycle: core model, DMA drive/pop, scoreboard update; always returns on a negedge
   task automatic step(input logic v, input logic [7:0] w, input logic rd);
      if (core_next === 1'b1) st = cyc;
      if (st >= 0 && cyc - st < F) begin
         check("core_in", 32'(core_in), exp_core.size() != 0 ? 32'(exp_core.pop_front()) : 32'h100);
         rq[cyc + lat] = ~core_in;
         if (cyc == st) pq[cyc + lat] = 1'b1;
      end
      core_next_out = pq.exists(cyc) || spur;
      core_out = rq.exists(cyc) ? rq[cyc] : (spur ? 8'h5A : 8'h00);
      s_valid = v;
      s_data = w;
      m_rd = rd;
      if (v && s_ready) begin
         exp_core.push_back(w);
         exp_out.push_back(~w);
      end
      if (rd && m_valid) check("m_data", 32'(m_data), exp_out.size() != 0 ? 32'(exp_out.pop_front()) : 32'h100);
      @(negedge clk);
      cyc++;
      s_valid = 1'b0;
      m_rd = 1'b0;
      if (frame_done) fd_cnt++;
      if (dev_ready) dr_seen = 1'b1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(1'b0, 8'h00, 1'b0);
      check("rst_s_ready", 32'(s_ready), 1);
      check("rst_dev_ready", 32'(dev_ready), 1);
      check("rst_dev_busy", 32'(dev_busy), 0);
      check("rst_m_valid", 32'(m_valid), 0);
      check("rst_m_data", 32'(m_data), 0);
      check("rst_core_next", 32'(core_next), 0);
      check("rst_core_in", 32'(core_in), 0);
      check("rst_frame_done", 32'(frame_done), 0);
      check("rst_ovf", 32'(ovf_err), 0);
      check("rst_unf", 32'(unf_err), 0);
`ifdef ACCEL_FRAME_CNT_EN
      check("rst_frame_cnt", 32'(frame_cnt), 0);
`endif
      rst = 1'b0;
      exp_core.delete();
      exp_out.delete();
      rq.delete();
      pq.delete();
      st = -1;
      fd_cnt = 0;
   endtask

   task automatic push_frame(input logic [31:0] ws);
      for (int i = 0; i < F; i++) step(1'b1, ws[31-8*i -: 8], 1'b0);
   endtask

   task automatic wait_flush();
      int n = 0;
      while ((dev_ready || dev_busy) && n < 40) begin
         step(1'b0, 8'h00, 1'b0);
         n++;
      end
      check("flush_reached", 32'(n < 40), 1);
   endtask

   task automatic drain();
      int n = 0;
      while (m_valid && n < 10) begin
         step(1'b0, 8'h00, 1'b1);
         n++;
      end
      check("drain_left", exp_out.size(), 0);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();
      push_frame(32'h11223344);
      check("core_next_single", 32'(core_next), 1);
      check("busy_single", 32'(dev_busy), 1);
      wait_flush();
      drain();
      check("frame_done_single", fd_cnt, 1);
      check("idle_after_single", 32'(dev_ready), 1);
`ifdef ACCEL_FRAME_CNT_EN
      check("frame_cnt_single", 32'(frame_cnt), 1);
`endif
      push_frame(32'hA1A2A3A4);
      dr_seen = 1'b0;
      wait_flush();
      for (int i = 0; i < F; i++) begin
         check("s_ready_flush", 32'(s_ready), 1);
         step(1'b1, 8'(8'hB1 + i), 1'b1);
      end
      check("core_next_overlap", 32'(core_next), 1);
      check("frame_done_overlap", 32'(frame_done), 1);
      check("dev_ready_never", 32'(dr_seen), 0);
      wait_flush();
      drain();
      push_frame(32'hC1C2C3C4);
      repeat (F) step(1'b0, 8'h00, 1'b0);
      check("s_ready_wait_out", 32'(s_ready), 0);
      step(1'b1, 8'h99, 1'b0);
      check("ovf_set", 32'(ovf_err), 1);
      err_clr = 1'b1;
      step(1'b0, 8'h00, 1'b0);
      err_clr = 1'b0;
      check("ovf_clr", 32'(ovf_err), 0);
      wait_flush();
      drain();
      step(1'b0, 8'h00, 1'b1);
      check("unf_set", 32'(unf_err), 1);
      check("unf_m_data", 32'(m_data), 0);
      err_clr = 1'b1;
      step(1'b0, 8'h00, 1'b1);
      check("unf_new_wins", 32'(unf_err), 1);
      step(1'b0, 8'h00, 1'b0);
      err_clr = 1'b0;
      check("unf_clr", 32'(unf_err), 0);
      lat = 1;
      spur = 1'b1;
      step(1'b0, 8'h00, 1'b0);
      spur = 1'b0;
      step(1'b0, 8'h00, 1'b0);
      check("spur_ignored", 32'(m_valid), 0);
      push_frame(32'h0F1E2D3C);
      wait_flush();
      drain();
      lat = 3;
      step(1'b0, 8'h00, 1'b1);
      check("unf_before_rst", 32'(unf_err), 1);
      push_frame(32'h55667788);
      repeat (F + 1) step(1'b0, 8'h00, 1'b0);
      check("wait_out_busy", 32'(dev_busy), 1);
      check("wait_out_partial", 32'(m_valid), 1);
      do_reset();
      push_frame(32'h01020304);
      wait_flush();
      drain();
      check("frame_done_after_rst", fd_cnt, 1);
`ifdef ACCEL_FRAME_CNT_EN
      check("frame_cnt_after_rst", 32'(frame_cnt), 1);
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
